// File: rtl/counter_mod_updown.sv
// Modulo-N up/down counter with per-bit transition pulses, wrap pulse,
// synchronous clamped load and a one-shot stop-at-terminal mode.
module counter_mod_updown #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             n_en,
    input  logic             dir,
    input  logic             n_load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] trig_out,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    typedef enum logic {
        ST_COUNTING = 1'b0,
        ST_DONE     = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_trig;
    logic             r_wrap;
    logic             r_done;

    logic             w_term;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_trig;
    logic [WIDTH-1:0] w_load;

    always_comb begin
        w_term = '0;
        w_nxt  = '0;
        w_trig = '0;
        if (dir) begin
            w_term = (r_count == '0);
            w_nxt  = w_term ? MAXV : r_count - 1'b1;
            w_trig = ~r_count & w_nxt;
        end else begin
            w_term = (r_count == MAXV);
            w_nxt  = w_term ? '0 : r_count + 1'b1;
            w_trig = r_count & ~w_nxt;
        end
    end

    // Out-of-range load values saturate to the top of the count range.
    assign w_load = (load_val > MAXV) ? MAXV : load_val;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_COUNTING;
            r_count <= '0;
            r_trig  <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else if (!n_load) begin
            r_state <= ST_COUNTING;
            r_count <= w_load;
            r_trig  <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else if (!n_en && r_state == ST_COUNTING) begin
            if (w_term && one_shot) begin
                r_state <= ST_DONE;
                r_trig  <= '0;
                r_wrap  <= 1'b1;
                r_done  <= 1'b1;
            end else begin
                r_count <= w_nxt;
                r_trig  <= w_trig;
                r_wrap  <= w_term;
            end
        end else begin
            r_trig <= '0;
            r_wrap <= 1'b0;
        end
    end

    assign count    = r_count;
    assign trig_out = r_trig;
    assign wrap     = r_wrap;
    assign done     = r_done;

endmodule
